fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of the decoder. Owns the PC and issues one
//  32-bit instruction request at a time on the ibus (req/data_ok). It buffers the returned
//  word with its PC in a one-entry output register and hands it to decode via valid/ready.
//  Accepts redirects (branch/jump/exception target) from later stages. A response to a
//  request overtaken by a redirect is discarded.
// PARAMETERS
//  XLEN      64            PC / address width
//  PC_RESET  64'h8000_0000 PC loaded on reset; low 2 bits must be 0
// PORTS
//  clk             in   1     clock; all state updates on rising edge
//  reset           in   1     asynchronous, active-low reset
//  ireq_valid      out  1     instruction request valid
//  ireq_addr       out  XLEN  instruction address; stable while ireq_valid is 1 and data_ok is 0
//  iresp_data_ok   in   1     response for current request; may be high in the request cycle
//  iresp_data      in   32    instruction word; valid when iresp_data_ok
//  redirect_valid  in   1     redirect the PC this cycle
//  redirect_pc     in   XLEN  new fetch target
//  out_valid       out  1     out_instr/out_pc hold an instruction for decode
//  out_ready       in   1     decode consumes the entry this cycle when out_valid
//  out_instr       out  32    raw instruction to decoder
//  out_pc          out  XLEN  PC of out_instr
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - pc = PC_RESET, state = FETCH.
//    - out_valid = 0, out_instr = 0, out_pc = 0, flush_addr = 0.
//    - ireq_valid = 0 while reset is low.
//  - States: FETCH (normal), FLUSH (draining a request killed by a redirect).
//  - Combinational request outputs:
//    - FETCH: ireq_valid = !out_valid | out_ready; ireq_addr = pc.
//    - FLUSH: ireq_valid = 1; ireq_addr = flush_addr.
//  - Bus rule: once ireq_valid is raised, it stays high with the same address until the
//    data_ok cycle. This is guaranteed because the buffer is empty after any cycle that
//    issued a request without data_ok.
//  - Accept (FETCH, ireq_valid & data_ok, no redirect):
//    - out_instr <= iresp_data; out_pc <= pc; out_valid <= 1.
//    - pc <= pc + 4, modulo 2^XLEN (wraps to 0).
//  - Consume: out_valid & out_ready with no accept that cycle -> out_valid <= 0.
//    Accept and consume in the same cycle overwrite the entry. Throughput is 1 instr/cycle.
//  - Redirect (priority over everything):
//    - pc <= {redirect_pc[XLEN-1:2], 2'b00}; out_valid <= 0.
//    - In FETCH with ireq_valid & !data_ok: flush_addr <= pc, go to FLUSH.
//    - In FETCH with data_ok in the same cycle: the response is dropped; stay in FETCH.
//    - In FLUSH: pc is updated and the state stays FLUSH; flush_addr is unchanged.
//  - FLUSH exit: on data_ok, the response is discarded, nothing is written to the buffer,
//    and the state goes to FETCH. The new pc is requested in the next cycle.
//  - Redirect and out_ready in the same cycle: the entry is dropped, not delivered.
//  - Reset mid-request: all state clears immediately. The bus is expected to be reset
//    alongside, so no stale response is tracked.
//  - Latency: with data_ok in the request cycle, out_valid rises in the next cycle.
//    After a redirect, the first target instruction is valid at the earliest 2 cycles later.
//  - No X on outputs after reset. out_instr/out_pc hold their values when out_valid = 0.
// TESTING
//  1. Release reset, memory returns data_ok in the same cycle with out_ready = 1:
//     ireq_addr = 8000_0000, 8000_0004, ...; out_valid is continuous with matching pc/instr.
//  2. out_ready = 0 for 3 cycles with the buffer full: ireq_valid = 0;
//     out_instr/out_pc stay stable; fetch resumes on the cycle out_ready returns to 1.
//  3. Response latency of 4 cycles: ireq_addr stays constant during the wait;
//     out_valid pulses once per request.
//  4. Redirect to 8000_1000 while the request to 8000_0008 is pending (data_ok in 2 cycles):
//     addr 8000_0008 is held until data_ok; that word never appears on out;
//     the next request is 8000_1000.
//  5. Redirect in the same cycle as data_ok: that word is dropped, out_valid = 0 in the
//     next cycle, and the next request goes to the target. redirect_pc = ...1002 fetches ...1000.
//  6. PC_RESET = 64'hFFFF_FFFF_FFFF_FFFC: the second request is addr 0.
//     Asserting reset mid-wait forces out_valid = 0 and ireq_valid = 0 immediately.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage, the instruction bus and the decoder.
// The master side is the fetch stage; the slave side is the memory/decode environment.
interface fetch_stage_if #(
  parameter int XLEN = 64
);
  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            iresp_data_ok;
  logic [31:0]     iresp_data;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    output ireq_valid, ireq_addr, out_valid, out_instr, out_pc,
    input  iresp_data_ok, iresp_data, out_ready
  );

  modport slave (
    input  ireq_valid, ireq_addr, out_valid, out_instr, out_pc,
    output iresp_data_ok, iresp_data, out_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one ibus request at a time and buffers the
// returned word with its PC in a one-entry register for decode. Redirects kill in-flight fetches.
module fetch_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  fetch_stage_if.master   bus,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  typedef enum logic {FETCH = 1'b0, FLUSH = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, flush_addr, out_pc_q;
  logic [31:0]     out_instr_q;
  logic            out_valid_q;
  logic            req, accept, consume;
  logic [XLEN-1:0] req_addr;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  // A killed request must still complete on the bus before a new address may be issued.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned
    // and infers a latch.
    state_nxt = state;
    case (state)
      FETCH: if (redirect_valid && req && !bus.iresp_data_ok) state_nxt = FLUSH;
      FLUSH: if (bus.iresp_data_ok)                          state_nxt = FETCH;
      default:                                               state_nxt = FETCH;
    endcase
  end

  always_comb begin
    req      = 1'b0;
    req_addr = pc;
    case (state)
      FETCH: begin
        req      = !out_valid_q || bus.out_ready;
        req_addr = pc;
      end
      FLUSH: begin
        req      = 1'b1;
        req_addr = flush_addr;
      end
      default: begin
        req      = 1'b0;
        req_addr = pc;
      end
    endcase
  end

  assign bus.ireq_valid = req && reset;
  assign bus.ireq_addr  = req_addr;

  assign accept  = (state == FETCH) && req && bus.iresp_data_ok && !redirect_valid;
  assign consume = out_valid_q && bus.out_ready;

  // NOTE: the one-entry buffer is reset too, since out_instr/out_pc must never show X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= PC_RESET;
      flush_addr  <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else if (redirect_valid) begin
      pc          <= {redirect_pc[XLEN-1:2], 2'b00};
      out_valid_q <= 1'b0;
      if (state == FETCH && req && !bus.iresp_data_ok) flush_addr <= pc;
    end else if (accept) begin
      pc          <= pc + XLEN'(4);
      out_valid_q <= 1'b1;
      out_instr_q <= bus.iresp_data;
      out_pc_q    <= pc;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table for streaming, back-pressure,
// latency and redirect cases, plus a hand sequence for PC wrap and reset mid-request.
module tb_fetch_stage;
  localparam int          XLEN = 64;
  localparam logic [63:0] B    = 64'h8000_0000;
  localparam logic [31:0] BAD  = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset, reset2;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic redirect_valid2;
  logic [XLEN-1:0] redirect_pc2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(XLEN)) bus ();
  fetch_stage_if #(.XLEN(XLEN)) bus2 ();

  fetch_stage #(.XLEN(XLEN), .PC_RESET(64'h8000_0000)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_stage #(.XLEN(XLEN), .PC_RESET(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset2), .bus(bus2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2)
  );

  typedef struct {
    logic        ok;
    logic [31:0] data;
    logic        rv;
    logic [63:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_ov;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs [28];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Expected columns are the outputs seen during the cycle, before its rising edge.
    vecs[0]  = '{1'b1, 32'hC0DE_0000, 1'b0, 64'h0,      1'b1, 1'b1, B+64'h0,    1'b0, 64'h0,      32'h0};
    vecs[1]  = '{1'b1, 32'hC0DE_0001, 1'b0, 64'h0,      1'b1, 1'b1, B+64'h4,    1'b1, B+64'h0,    32'hC0DE_0000};
    vecs[2]  = '{1'b1, 32'hC0DE_0002, 1'b0, 64'h0,      1'b1, 1'b1, B+64'h8,    1'b1, B+64'h4,    32'hC0DE_0001};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 64'h0,      1'b0, 1'b0, B+64'hC,    1'b1, B+64'h8,    32'hC0DE_0002};
    vecs[4]  = '{1'b0, 32'h0,         1'b0, 64'h0,      1'b0, 1'b0, B+64'hC,    1'b1, B+64'h8,    32'hC0DE_0002};
    vecs[5]  = '{1'b0, 32'h0,         1'b0, 64'h0,      1'b0, 1'b0, B+64'hC,    1'b1, B+64'h8,    32'hC0DE_0002};
    vecs[6]  = '{1'b1, 32'hC0DE_0003, 1'b0, 64'h0,      1'b1, 1'b1, B+64'hC,    1'b1, B+64'h8,    32'hC0DE_0002};
    vecs[7]  = '{1'b0, 32'h0,         1'b0, 64'h0,      1'b1, 1'b1, B+64'h10,   1'b1, B+64'hC,    32'hC0DE_0003};
    vecs[8]  = '{1'b0, 32'h0,         1'b0, 64'h0,      1'b1, 1'b1, B+64'h10,   1'b0, B+64'hC,    32'hC0DE_0003};
    vecs[9]  = '{1'b0, 32'h0,         1'b0, 64'h0,      1'b1, 1'b1, B+64'h10,   1'b0, B+64'hC,    32'hC0DE_0003};
    vecs[10] = '{1'b1, 32'hC0DE_0004, 1'b0, 64'h0,      1'b1, 1'b1, B+64'h10,   1'b0, B+64'hC,    32'hC0DE_0003};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 64'h0,      1'b1, 1'b1, B+64'h14,   1'b1, B+64'h10,   32'hC0DE_0004};
    vecs[12] = '{1'b0, 32'h0,         1'b0, 64'h0,      1'b1, 1'b1, B+64'h14,   1'b0, B+64'h10,   32'hC0DE_0004};
    vecs[13] = '{1'b0, 32'h0,         1'b0, 64'h0,      1'b1, 1'b1, B+64'h14,   1'b0, B+64'h10,   32'hC0DE_0004};
    vecs[14] = '{1'b1, 32'hC0DE_0005, 1'b0, 64'h0,      1'b1, 1'b1, B+64'h14,   1'b0, B+64'h10,   32'hC0DE_0004};
    vecs[15] = '{1'b0, 32'h0,         1'b1, B+64'h1000, 1'b1, 1'b1, B+64'h18,   1'b1, B+64'h14,   32'hC0DE_0005};
    vecs[16] = '{1'b0, 32'h0,         1'b0, 64'h0,      1'b1, 1'b1, B+64'h18,   1'b0, B+64'h14,   32'hC0DE_0005};
    vecs[17] = '{1'b1, BAD,           1'b0, 64'h0,      1'b1, 1'b1, B+64'h18,   1'b0, B+64'h14,   32'hC0DE_0005};
    vecs[18] = '{1'b1, 32'hC0DE_0006, 1'b0, 64'h0,      1'b1, 1'b1, B+64'h1000, 1'b0, B+64'h14,   32'hC0DE_0005};
    vecs[19] = '{1'b1, BAD,           1'b1, B+64'h2002, 1'b1, 1'b1, B+64'h1004, 1'b1, B+64'h1000, 32'hC0DE_0006};
    vecs[20] = '{1'b1, 32'hC0DE_0007, 1'b0, 64'h0,      1'b1, 1'b1, B+64'h2000, 1'b0, B+64'h1000, 32'hC0DE_0006};
    vecs[21] = '{1'b0, 32'h0,         1'b0, 64'h0,      1'b0, 1'b0, B+64'h2004, 1'b1, B+64'h2000, 32'hC0DE_0007};
    vecs[22] = '{1'b0, 32'h0,         1'b0, 64'h0,      1'b1, 1'b1, B+64'h2004, 1'b1, B+64'h2000, 32'hC0DE_0007};
    vecs[23] = '{1'b0, 32'h0,         1'b1, B+64'h3000, 1'b1, 1'b1, B+64'h2004, 1'b0, B+64'h2000, 32'hC0DE_0007};
    vecs[24] = '{1'b0, 32'h0,         1'b1, B+64'h4000, 1'b1, 1'b1, B+64'h2004, 1'b0, B+64'h2000, 32'hC0DE_0007};
    vecs[25] = '{1'b1, BAD,           1'b0, 64'h0,      1'b1, 1'b1, B+64'h2004, 1'b0, B+64'h2000, 32'hC0DE_0007};
    vecs[26] = '{1'b1, 32'hC0DE_0008, 1'b0, 64'h0,      1'b1, 1'b1, B+64'h4000, 1'b0, B+64'h2000, 32'hC0DE_0007};
    vecs[27] = '{1'b0, 32'h0,         1'b0, 64'h0,      1'b1, 1'b1, B+64'h4004, 1'b1, B+64'h4000, 32'hC0DE_0008};

    reset = 1'b0;
    reset2 = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    redirect_valid2 = 1'b0;
    redirect_pc2 = '0;
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data = 32'h0;
    bus.out_ready = 1'b1;
    bus2.iresp_data_ok = 1'b0;
    bus2.iresp_data = 32'h0;
    bus2.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ireq_valid", 64'(bus.ireq_valid), 64'h0);
    check("rst_out_valid",  64'(bus.out_valid),  64'h0);
    check("rst_out_pc",     bus.out_pc,          64'h0);
    check("rst_out_instr",  64'(bus.out_instr),  64'h0);
    reset = 1'b1;

    for (int i = 0; i < 28; i++) begin
      bus.iresp_data_ok = vecs[i].ok;
      bus.iresp_data    = vecs[i].data;
      redirect_valid    = vecs[i].rv;
      redirect_pc       = vecs[i].rpc;
      bus.out_ready     = vecs[i].rdy;
      #1;
      check($sformatf("v%0d_ireq_valid", i), 64'(bus.ireq_valid), 64'(vecs[i].e_req));
      check($sformatf("v%0d_ireq_addr", i),  bus.ireq_addr,        vecs[i].e_addr);
      check($sformatf("v%0d_out_valid", i),  64'(bus.out_valid),  64'(vecs[i].e_ov));
      check($sformatf("v%0d_out_pc", i),     bus.out_pc,          vecs[i].e_pc);
      check($sformatf("v%0d_out_instr", i),  64'(bus.out_instr),  64'(vecs[i].e_instr));
      @(negedge clk);
    end
    redirect_valid = 1'b0;

    // PC wrap: the request after FFFF_FFFF_FFFF_FFFC goes to address 0.
    reset2 = 1'b1;
    bus2.iresp_data_ok = 1'b1;
    bus2.iresp_data    = 32'hAAAA_0001;
    #1;
    check("wrap_addr0", bus2.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    bus2.iresp_data = 32'hAAAA_0002;
    #1;
    check("wrap_addr1",   bus2.ireq_addr,         64'h0);
    check("wrap_out_pc0", bus2.out_pc,            64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_instr0",  64'(bus2.out_instr),    64'hAAAA_0001);
    @(negedge clk);
    bus2.iresp_data_ok = 1'b0;
    #1;
    check("wrap_out_pc1", bus2.out_pc,            64'h0);
    check("wrap_wait_req", 64'(bus2.ireq_valid),  64'h1);
    check("wrap_wait_addr", bus2.ireq_addr,       64'h4);
    check("wrap_wait_ov", 64'(bus2.out_valid),    64'h1);

    // Reset asserted mid-wait clears outputs without waiting for a clock edge.
    reset2 = 1'b0;
    #1;
    check("midrst_ireq_valid", 64'(bus2.ireq_valid), 64'h0);
    check("midrst_out_valid",  64'(bus2.out_valid),  64'h0);
    check("midrst_out_pc",     bus2.out_pc,          64'h0);
    check("midrst_out_instr",  64'(bus2.out_instr),  64'h0);
    check("midrst_addr",       bus2.ireq_addr,       64'hFFFF_FFFF_FFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
